// File: rtl/rca_pkg.sv
// Shared constants for the pipelined ripple-carry adder.
// Mode encodings and default geometry.
package rca_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry chain.
// One instance resolves one pipeline segment.
module rca_seg
  import rca_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SEG];

endmodule

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry add/sub, SEG bits per stage.
// Valid/ready at both ends; a stall freezes every stage.
module rca_pipe_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGES = WIDTH / SEG;

  if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_bad_geom
    $error("rca_pipe_adder: WIDTH must be a multiple of SEG");
  end

  logic adv;

  logic [NSTAGES-1:0] v_q, v_d, v_x;
  logic [NSTAGES-1:0] c_q, c_d, c_x;

  logic [WIDTH-1:0] a_q [NSTAGES];
  logic [WIDTH-1:0] a_d [NSTAGES];
  logic [WIDTH-1:0] a_x [NSTAGES];
  logic [WIDTH-1:0] b_q [NSTAGES];
  logic [WIDTH-1:0] b_d [NSTAGES];
  logic [WIDTH-1:0] b_x [NSTAGES];
  logic [WIDTH-1:0] s_q [NSTAGES];
  logic [WIDTH-1:0] s_d [NSTAGES];
  logic [WIDTH-1:0] s_x [NSTAGES];

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv && !rst;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int LSB = k * SEG;
    localparam logic [WIDTH-1:0] MASK =
      WIDTH'({SEG{1'b1}}) << LSB;

    logic [SEG-1:0] seg_s;
    logic           seg_c;

    if (k == 0) begin : g_first
      // b is inverted once here; later stages see b_eff only
      assign a_x[k] = a;
      assign b_x[k] = (sub == MODE_SUB) ? ~b : b;
      assign s_x[k] = '0;
      assign c_x[k] = cin ^ sub;
      assign v_x[k] = in_valid && in_ready;
    end else begin : g_next
      assign a_x[k] = a_q[k-1];
      assign b_x[k] = b_q[k-1];
      assign s_x[k] = s_q[k-1];
      assign c_x[k] = c_q[k-1];
      assign v_x[k] = v_q[k-1];
    end

    rca_seg #(.SEG(SEG)) u_seg (
      .a    (a_x[k][LSB +: SEG]),
      .b    (b_x[k][LSB +: SEG]),
      .cin  (c_x[k]),
      .sum  (seg_s),
      .cout (seg_c)
    );

    assign s_d[k] = (s_x[k] & ~MASK) |
                    (WIDTH'(seg_s) << LSB);
    assign a_d[k] = a_x[k];
    assign b_d[k] = b_x[k];
    assign c_d[k] = seg_c;
    assign v_d[k] = v_x[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = v_q[NSTAGES-1];
  assign sum       = s_q[NSTAGES-1];
  assign cout      = c_q[NSTAGES-1];
  assign ovf       =
    (a_q[NSTAGES-1][WIDTH-1] == b_q[NSTAGES-1][WIDTH-1]) &&
    (s_q[NSTAGES-1][WIDTH-1] != a_q[NSTAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Directed bench for rca_pipe_adder: 16/4 pipeline
// plus a 16/16 single-stage build against a model.
module tb_rca_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic        cout, ovf;

  logic        in_valid2, in_ready2;
  logic [15:0] a2, b2, sum2;
  logic        cin2, sub2;
  logic        out_valid2, out_ready2;
  logic        cout2, ovf2;

  int nvec = 0;
  int nerr = 0;

  localparam logic [15:0] EXP_S [8] = '{
    16'h0F0F, 16'h2020, 16'h3131, 16'h4242,
    16'h5353, 16'h6464, 16'h7575, 16'h8686};
  localparam logic EXP_O [8] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  rca_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  rca_pipe_adder #(.WIDTH(16), .SEG(16)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .cin       (cin2),
    .sub       (sub2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .cout      (cout2),
    .ovf       (ovf2)
  );

  // Issue one operation and wait (bounded) for its result.
  task automatic run_op(
    input  logic [15:0] ia, ib,
    input  logic        icin, isub,
    output logic [15:0] os,
    output logic        oc, oo,
    output int          lat
  );
    a = ia; b = ib; cin = icin; sub = isub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    os = sum; oc = cout; oo = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_valid2 = 1'b1;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
    a2 = 16'h1111; b2 = 16'h2222; cin2 = 1'b0; sub2 = 1'b0;
    out_ready = 1'b1; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    nvec++;
    if (sum !== 16'h0000) begin
      nerr++; $display("FAIL rst_sum got %h want 0000", sum);
    end
    nvec++;
    if ({cout, ovf} !== 2'b00) begin
      nerr++; $display("FAIL rst_cout_ovf got %b want 00", {cout, ovf});
    end
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL rst_in_ready got %b want 0", in_ready);
    end
    nvec++;
    if (out_valid2 !== 1'b0) begin
      nerr++; $display("FAIL rst_out_valid_s1 got %b want 0", out_valid2);
    end
    rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL post_rst_in_ready got %b want 1", in_ready);
    end
    begin
      logic seen;
      seen = 1'b0;
      repeat (6) begin
        if (out_valid || out_valid2) seen = 1'b1;
        @(posedge clk); #1;
      end
      nvec++;
      if (seen !== 1'b0) begin
        nerr++; $display("FAIL rst_in_valid_ignored got %b want 0", seen);
      end
    end
  endtask

  task automatic test_add();
    logic [15:0] s;
    logic        c, o;
    int          lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
    nvec++;
    if (lat !== 4) begin
      nerr++; $display("FAIL add_wrap_latency got %0d want 4", lat);
    end
    nvec++;
    if ({s, c, o} !== {16'h0000, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL add_wrap got %h/%b/%b want 0000/1/0", s, c, o);
    end
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
    nvec++;
    if ({s, c, o} !== {16'h8000, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL add_ovf got %h/%b/%b want 8000/0/1", s, c, o);
    end
    run_op(16'h1234, 16'h1111, 1'b1, 1'b0, s, c, o, lat);
    nvec++;
    if ({s, c, o} !== {16'h2346, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL add_cin got %h/%b/%b want 2346/0/0", s, c, o);
    end
  endtask

  task automatic test_sub();
    logic [15:0] s;
    logic        c, o;
    int          lat;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, c, o, lat);
    nvec++;
    if ({s, c, o} !== {16'hFFFE, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL sub_neg got %h/%b/%b want fffe/0/0", s, c, o);
    end
    nvec++;
    if (lat !== 4) begin
      nerr++; $display("FAIL sub_latency got %0d want 4", lat);
    end
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, s, c, o, lat);
    nvec++;
    if ({s, c, o} !== {16'hFFFD, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL sub_borrow got %h/%b/%b want fffd/0/0", s, c, o);
    end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, o, lat);
    nvec++;
    if ({s, c, o} !== {16'h7FFF, 1'b1, 1'b1}) begin
      nerr++; $display("FAIL sub_ovf got %h/%b/%b want 7fff/1/1", s, c, o);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin : drv
        for (int i = 0; i < 8; i++) begin
          logic acc;
          int   w;
          a = 16'(i) * 16'h1111; b = 16'h0F0F;
          cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
          acc = 1'b0; w = 0;
          do begin
            @(negedge clk); #1;
            acc = in_ready;
            @(posedge clk); #1;
            w++;
          end while (!acc && w < 20);
          if (!acc) begin
            nvec++; nerr++;
            $display("FAIL b2b_accept_timeout vec %0d got none want accept", i);
          end
        end
        in_valid = 1'b0;
      end
      begin : col
        int got, stall_left, cyc;
        logic stalled;
        got = 0; stall_left = 0; stalled = 1'b0; cyc = 0;
        while (got < 8 && cyc < 60) begin
          @(posedge clk); #1;
          cyc++;
          if (!stalled && got == 3) begin
            stalled = 1'b1; stall_left = 3;
          end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
          @(negedge clk);
          if (!out_ready) begin
            nvec++;
            if ({out_valid, in_ready} !== 2'b10) begin
              nerr++;
              $display("FAIL b2b_stall_ctl got v=%b r=%b want v=1 r=0", out_valid, in_ready);
            end
            nvec++;
            if (sum !== EXP_S[got]) begin
              nerr++; $display("FAIL b2b_stall_hold got %h want %h", sum, EXP_S[got]);
            end
            nvec++;
            if ({cout, ovf} !== {1'b0, EXP_O[got]}) begin
              nerr++;
              $display("FAIL b2b_stall_flags got %b%b want 0%b", cout, ovf, EXP_O[got]);
            end
          end else if (out_valid) begin
            nvec++;
            if (sum !== EXP_S[got]) begin
              nerr++; $display("FAIL b2b_sum[%0d] got %h want %h", got, sum, EXP_S[got]);
            end
            nvec++;
            if ({cout, ovf} !== {1'b0, EXP_O[got]}) begin
              nerr++;
              $display("FAIL b2b_flags[%0d] got %b%b want 0%b", got, cout, ovf, EXP_O[got]);
            end
            got++;
          end
        end
        out_ready = 1'b1;
        nvec++;
        if (got !== 8) begin
          nerr++; $display("FAIL b2b_count got %0d want 8", got);
        end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(i + 1); b = 16'h0001;
      cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if ({out_valid, in_ready} !== 2'b00) begin
      nerr++;
      $display("FAIL mid_rst got v=%b r=%b want v=0 r=0", out_valid, in_ready);
    end
    nvec++;
    if (sum !== 16'h0000) begin
      nerr++; $display("FAIL mid_rst_sum got %h want 0000", sum);
    end
    rst = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      nerr++; $display("FAIL mid_rst_stale got %b want 0", seen);
    end
  endtask

  task automatic test_seg16();
    out_ready2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra, rb, be;
      logic        rc, rs, eo;
      logic [16:0] full;
      if (i == 0) begin
        ra = 16'h7FFF; rb = 16'h0001; rc = 1'b0; rs = 1'b0;
      end else begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom); rs = 1'($urandom);
      end
      be   = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, be} + 17'(rc ^ rs);
      eo   = (ra[15] == be[15]) && (full[15] != ra[15]);
      a2 = ra; b2 = rb; cin2 = rc; sub2 = rs; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      nvec++;
      if (out_valid2 !== 1'b1) begin
        nerr++; $display("FAIL s1_latency[%0d] got v=%b want 1", i, out_valid2);
      end
      nvec++;
      if ({cout2, sum2, ovf2} !== {full, eo}) begin
        nerr++;
        $display("FAIL s1_result[%0d] got %b/%h/%b want %b/%h/%b", i, cout2, sum2, ovf2, full[16], full[15:0], eo);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_seg16();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rca_pipe_adder.md
RCA_PIPE_ADDER -- requirements
Module: rca_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter SEG, default 4, bits resolved per pipeline stage.
REQ-003 Derived NSTAGES = WIDTH/SEG; WIDTH not an integer multiple of SEG SHALL be an elaboration error.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operand set present.
REQ-007 in_ready  out  1  block accepts operands this cycle.
REQ-008 a  in  WIDTH  operand A.
REQ-009 b  in  WIDTH  operand B.
REQ-010 cin  in  1  carry-in (add) / borrow-in (sub).
REQ-011 sub  in  1  mode: 0 add, 1 subtract.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 sum  out  WIDTH  result.
REQ-015 cout  out  1  raw carry out of MSB.
REQ-016 ovf  out  1  two's-complement signed overflow.

Function
REQ-017 Transfer on input when in_valid & in_ready; transfer on output when out_valid & out_ready.
REQ-018 Effective operand SHALL be b_eff = sub ? ~b : b; carry into bit 0 SHALL be cin ^ sub (sub, cin=0 gives a-b; sub, cin=1 gives a-b-1).
REQ-019 Stage k (0..NSTAGES-1) SHALL resolve bits [k*SEG +: SEG] with one SEG-bit ripple chain, registering partial sum, carry, and unresolved upper operand bits into the next stage.
REQ-020 Latency SHALL be exactly NSTAGES cycles from input transfer to out_valid high, absent stalls.
REQ-021 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-022 Each stage SHALL carry its own valid bit; bubbles propagate and never produce out_valid.
REQ-023 Pipeline SHALL advance when !(out_valid & !out_ready); otherwise every stage holds its contents.
REQ-024 in_ready SHALL equal the advance condition, combinationally, and SHALL be 0 while rst is high.
REQ-025 Held outputs (sum, cout, ovf) SHALL remain stable while out_valid & !out_ready.
REQ-026 ovf SHALL equal (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
REQ-027 Results SHALL leave in acceptance order; no transaction is dropped or duplicated.
REQ-028 With SEG == WIDTH the block SHALL be a single registered stage with latency 1.

Reset
REQ-029 On rst high at a clock edge, all stage valid bits, out_valid, sum, cout, and ovf SHALL clear to 0 on that edge.
REQ-030 Reset mid-operation SHALL discard all in-flight transactions; no stale result appears after rst deasserts.
REQ-031 in_valid during rst SHALL be ignored.

Structure
REQ-032 Shared package rca_pkg SHALL hold MODE_ADD=0/MODE_SUB=1 constants and default WIDTH/SEG values.
REQ-033 Sub-module rca_seg (combinational SEG-bit ripple chain: a, b, cin -> sum, cout) SHALL be instantiated once per stage.
REQ-034 Stage registers and valid bits SHALL be held in generate-loop arrays indexed by stage.

Verification (WIDTH=16, SEG=4 unless stated)
REQ-035 0xFFFF + 0x0001, cin=0, sub=0 -> sum 0x0000, cout 1, ovf 0, out_valid exactly 4 cycles after acceptance.
REQ-036 0x7FFF + 0x0001, sub=0 -> sum 0x8000, cout 0, ovf 1.
REQ-037 0x0005 - 0x0007, cin=0, sub=1 -> sum 0xFFFE, cout 0, ovf 0; same operands with cin=1 -> sum 0xFFFD.
REQ-038 Eight back-to-back inputs with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, outputs held stable, all 8 results in order.
REQ-039 rst pulsed 2 cycles after accepting 3 operations -> out_valid 0 from the next edge, no result emitted afterwards.
REQ-040 SEG=16 build with random operands versus reference model -> latency 1, all fields match.
